// File: rtl/pcc_rule_sched.sv
// Sequencer that time-shares one external popcount-compare across a programmable rule table,
// counting rules that fire and returning a vote total and a thresholded decision.
module pcc_rule_sched #(
  parameter int unsigned N_FEAT  = 16,
  parameter int unsigned N_RULES = 8,
  parameter int unsigned IDXW    = $clog2(N_FEAT),
  parameter int unsigned VW      = $clog2(N_RULES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_FEAT-1:0]            in_feat,
  input  logic                         cfg_we,
  input  logic [$clog2(N_RULES+1)-1:0] cfg_addr,
  input  logic [15*IDXW-1:0]           cfg_data,
  output logic [5:0]                   pcc_pos,
  output logic [8:0]                   pcc_neg,
  input  logic                         pcc_outval,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [VW-1:0]                votes,
  output logic                         decision,
  output logic                         busy
);

  localparam int unsigned AW = $clog2(N_RULES + 1);
  localparam int unsigned DW = 15 * IDXW;
  localparam int unsigned PW = (N_RULES > 1) ? $clog2(N_RULES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_FEAT-1:0] feat_q, feat_d;
  logic [VW-1:0]     votes_q, votes_d;
  logic              decision_q, decision_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic [5:0]        pos_q, pos_d;
  logic [8:0]        neg_q, neg_d;

  logic [DW-1:0]     rule_q [N_RULES];
  logic [VW-1:0]     nrules_q, thresh_q;

  // A write arriving with an accepted sample is parked here until that sample completes.
  logic              cfgb_valid_q;
  logic [AW-1:0]     cfgb_addr_q;
  logic [DW-1:0]     cfgb_data_q;

  logic              buf_load, buf_apply, apply_we;
  logic [AW-1:0]     apply_addr;
  logic [DW-1:0]     apply_data;
  logic [VW-1:0]     nrules_wr;
  logic [DW-1:0]     rule_sel;
  logic              last_rule;

  function automatic logic feat_bit(input logic [N_FEAT-1:0] f, input logic [IDXW-1:0] idx);
    if (int'(idx) < int'(N_FEAT)) return f[idx];
    return 1'b0;
  endfunction

  always_comb begin
    buf_apply  = (state_q == StDone) && out_ready && cfgb_valid_q;
    buf_load   = (state_q == StIdle) && cfg_we && in_valid;
    apply_we   = buf_apply || ((state_q == StIdle) && cfg_we && !in_valid);
    apply_addr = buf_apply ? cfgb_addr_q : cfg_addr;
    apply_data = buf_apply ? cfgb_data_q : cfg_data;
    nrules_wr  = (apply_data[VW-1:0] > VW'(N_RULES)) ? VW'(N_RULES) : apply_data[VW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(N_RULES); r++) rule_q[r] <= '0;
      nrules_q     <= '0;
      thresh_q     <= '0;
      cfgb_valid_q <= 1'b0;
      cfgb_addr_q  <= '0;
      cfgb_data_q  <= '0;
    end else begin
      if (apply_we) begin
        if (int'(apply_addr) < int'(N_RULES)) begin
          rule_q[apply_addr[PW-1:0]] <= apply_data;
        end else if (int'(apply_addr) == int'(N_RULES)) begin
          nrules_q <= nrules_wr;
          thresh_q <= apply_data[2*VW-1:VW];
        end
      end
      if (buf_load) begin
        cfgb_valid_q <= 1'b1;
        cfgb_addr_q  <= cfg_addr;
        cfgb_data_q  <= cfg_data;
      end else if (buf_apply) begin
        cfgb_valid_q <= 1'b0;
      end
    end
  end

  assign rule_sel  = rule_q[ptr_q];
  assign last_rule = (VW'(ptr_q) == (nrules_q - VW'(1)));

  always_comb begin
    state_d    = state_q;
    feat_d     = feat_q;
    votes_d    = votes_q;
    decision_d = decision_q;
    ptr_d      = ptr_q;
    pend_d     = pend_q;
    pos_d      = pos_q;
    neg_d      = neg_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          feat_d     = in_feat;
          votes_d    = '0;
          decision_d = 1'b0;
          ptr_d      = '0;
          pend_d     = 1'b0;
          // An empty table skips RUN; DRAIN adds nothing since pend is clear.
          state_d    = (nrules_q == '0) ? StDrain : StRun;
        end
      end
      StRun: begin
        for (int i = 0; i < 6; i++) pos_d[i] = feat_bit(feat_q, rule_sel[i*IDXW +: IDXW]);
        for (int j = 0; j < 9; j++) neg_d[j] = feat_bit(feat_q, rule_sel[(6+j)*IDXW +: IDXW]);
        pend_d = 1'b1;
        if (pend_q) votes_d = votes_q + VW'(pcc_outval);
        ptr_d = ptr_q + PW'(1);
        if (last_rule) state_d = StDrain;
      end
      StDrain: begin
        if (pend_q) votes_d = votes_q + VW'(pcc_outval);
        pend_d     = 1'b0;
        decision_d = (votes_d >= thresh_q);
        state_d    = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      feat_q     <= '0;
      votes_q    <= '0;
      decision_q <= 1'b0;
      ptr_q      <= '0;
      pend_q     <= 1'b0;
      pos_q      <= '0;
      neg_q      <= '0;
    end else begin
      state_q    <= state_d;
      feat_q     <= feat_d;
      votes_q    <= votes_d;
      decision_q <= decision_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign votes     = votes_q;
  assign decision  = decision_q;
  assign pcc_pos   = pos_q;
  assign pcc_neg   = neg_q;

endmodule
